vga_mode_ctrl: RTL

//  Mode sequencer in front of the vga timing generator. Owns its hd/hf/hr/hb/vd/vf/vr/vb/we inputs.

---
 rtl/vga_mode_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vga_mode_ctrl.sv
// Mode sequencer for the vga timing generator: accepts mode-change requests, applies them on a
// frame boundary, and holds the picture blanked while the new timing settles.
module vga_mode_ctrl #(
  parameter int unsigned DEFAULT_MODE    = 0,
  parameter int unsigned SETTLE_FRAMES   = 2,
  parameter int unsigned FCNT_W          = 4,
  parameter int unsigned VGA_MAX_H_WIDTH = 11,
  parameter int unsigned VGA_MAX_V_WIDTH = 10
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [1:0]                 req_mode_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] cust_hd_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] cust_hf_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] cust_hr_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] cust_hb_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] cust_vd_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] cust_vf_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] cust_vr_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] cust_vb_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] hcount_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] vcount_i,
  output logic [VGA_MAX_H_WIDTH-1:0] hd_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hf_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hr_o,
  output logic [VGA_MAX_H_WIDTH-1:0] hb_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vd_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vf_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vr_o,
  output logic [VGA_MAX_V_WIDTH-1:0] vb_o,
  output logic                       we_o,
  output logic                       blank_o,
  output logic [1:0]                 active_mode_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int unsigned HW = VGA_MAX_H_WIDTH;
  localparam int unsigned VW = VGA_MAX_V_WIDTH;

  // Timing sets are packed {d, f, r, b}, d in the top slice.
  function automatic logic [4*HW-1:0] tbl_h(input logic [1:0] m);
    case (m)
      2'd1:    tbl_h = {HW'(800), HW'(40), HW'(128), HW'(88)};
      2'd2:    tbl_h = {HW'(1024), HW'(24), HW'(136), HW'(160)};
      default: tbl_h = {HW'(640), HW'(16), HW'(96), HW'(48)};
    endcase
  endfunction

  function automatic logic [4*VW-1:0] tbl_v(input logic [1:0] m);
    case (m)
      2'd1:    tbl_v = {VW'(600), VW'(1), VW'(4), VW'(23)};
      2'd2:    tbl_v = {VW'(768), VW'(3), VW'(6), VW'(29)};
      default: tbl_v = {VW'(480), VW'(10), VW'(2), VW'(33)};
    endcase
  endfunction

  function automatic logic [HW-1:0] sum_h(input logic [4*HW-1:0] t);
    sum_h = t[4*HW-1 -: HW] + t[3*HW-1 -: HW] + t[2*HW-1 -: HW] + t[HW-1:0];
  endfunction

  function automatic logic [VW-1:0] sum_v(input logic [4*VW-1:0] t);
    sum_v = t[4*VW-1 -: VW] + t[3*VW-1 -: VW] + t[2*VW-1 -: VW] + t[VW-1:0];
  endfunction

  localparam logic [1:0]      DefMode = DEFAULT_MODE[1:0];
  localparam logic [4*HW-1:0] DefH    = tbl_h(DefMode);
  localparam logic [4*VW-1:0] DefV    = tbl_v(DefMode);
  localparam logic [HW-1:0]   DefHTot = sum_h(DefH);
  localparam logic [VW-1:0]   DefVTot = sum_v(DefV);

  typedef enum logic [1:0] {StBoot, StIdle, StPending, StSettle} state_e;

  state_e            r_state;
  logic [4*HW-1:0]   r_h, r_stg_h;
  logic [4*VW-1:0]   r_v, r_stg_v;
  logic [HW-1:0]     r_act_htot, r_stg_htot;
  logic [VW-1:0]     r_act_vtot, r_stg_vtot;
  logic [1:0]        r_mode, r_stg_mode;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_we, r_blank, r_ready, r_done, r_err, r_boot;

  logic [4*HW-1:0]   w_req_h;
  logic [4*VW-1:0]   w_req_v;
  logic              w_cust_ok;
  logic              w_frame_end;

  assign w_req_h = (req_mode_i == 2'd3) ? {cust_hd_i, cust_hf_i, cust_hr_i, cust_hb_i}
                                        : tbl_h(req_mode_i);
  assign w_req_v = (req_mode_i == 2'd3) ? {cust_vd_i, cust_vf_i, cust_vr_i, cust_vb_i}
                                        : tbl_v(req_mode_i);

  // Display width must exceed every porch/sync width so the outputs stay a legal mode.
  assign w_cust_ok = (cust_hd_i > cust_hf_i) && (cust_hd_i > cust_hr_i) && (cust_hd_i > cust_hb_i) &&
                     (cust_vd_i > cust_vf_i) && (cust_vd_i > cust_vr_i) && (cust_vd_i > cust_vb_i);

  assign w_frame_end = (hcount_i == r_act_htot - HW'(1)) && (vcount_i == r_act_vtot - VW'(1));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state    <= StBoot;
      r_h        <= DefH;
      r_v        <= DefV;
      r_stg_h    <= DefH;
      r_stg_v    <= DefV;
      r_act_htot <= DefHTot;
      r_act_vtot <= DefVTot;
      r_stg_htot <= DefHTot;
      r_stg_vtot <= DefVTot;
      r_mode     <= DefMode;
      r_stg_mode <= DefMode;
      r_fcnt     <= '0;
      r_we       <= 1'b0;
      r_blank    <= 1'b1;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_boot     <= 1'b1;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        // Generator state after reset is unknown, so program it without a boundary wait.
        StBoot: begin
          r_we    <= 1'b1;
          r_fcnt  <= '0;
          r_boot  <= 1'b1;
          r_state <= StSettle;
        end
        StIdle: begin
          if (req_valid_i && r_ready) begin
            if (req_mode_i != 2'd3 && req_mode_i == r_mode) begin
              r_done <= 1'b1;
            end else if (req_mode_i == 2'd3 && !w_cust_ok) begin
              r_err <= 1'b1;
            end else begin
              r_stg_h    <= w_req_h;
              r_stg_v    <= w_req_v;
              r_stg_htot <= sum_h(w_req_h);
              r_stg_vtot <= sum_v(w_req_v);
              r_stg_mode <= req_mode_i;
              r_ready    <= 1'b0;
              r_blank    <= 1'b1;
              r_state    <= StPending;
            end
          end
        end
        StPending: begin
          if (w_frame_end) begin
            r_h        <= r_stg_h;
            r_v        <= r_stg_v;
            r_act_htot <= r_stg_htot;
            r_act_vtot <= r_stg_vtot;
            r_mode     <= r_stg_mode;
            r_we       <= 1'b1;
            r_fcnt     <= '0;
            r_boot     <= 1'b0;
            r_state    <= StSettle;
          end
        end
        StSettle: begin
          if (w_frame_end) begin
            if (r_fcnt == FCNT_W'(SETTLE_FRAMES - 1)) begin
              r_state <= StIdle;
              r_blank <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= !r_boot;
            end else begin
              r_fcnt <= r_fcnt + FCNT_W'(1);
            end
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  assign hd_o          = r_h[4*HW-1 -: HW];
  assign hf_o          = r_h[3*HW-1 -: HW];
  assign hr_o          = r_h[2*HW-1 -: HW];
  assign hb_o          = r_h[HW-1:0];
  assign vd_o          = r_v[4*VW-1 -: VW];
  assign vf_o          = r_v[3*VW-1 -: VW];
  assign vr_o          = r_v[2*VW-1 -: VW];
  assign vb_o          = r_v[VW-1:0];
  assign we_o          = r_we;
  assign blank_o       = r_blank;
  assign req_ready_o   = r_ready;
  assign active_mode_o = r_mode;
  assign done_o        = r_done;
  assign err_o         = r_err;

endmodule
